// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI responder in front of a 16 x 8-bit register file.
// All SPI pins are oversampled in the clk domain. Byte 0 of a frame is a
// command (bit7 = read, bits3:0 = start address). The following bytes stream
// into or out of consecutive registers, with the address wrapping modulo 16.
module spi_reg_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       CPOL,
  input  logic       CPHA,
  output logic       busy,
  input  logic [3:0] loc_addr,
  output logic [7:0] loc_rdata,
  input  logic       loc_we,
  input  logic [7:0] loc_wdata,
  output logic       spi_wr,
  output logic [3:0] spi_wr_addr,
  output logic [7:0] spi_wr_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  // Synchronizer stages, bit order {SCLK, CS, MOSI}
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       cs_prev_q, cs_prev_d;
  logic       cs_armed_q, cs_armed_d;

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic       sample_edge, shift_edge, cs_fall;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       miso_q, miso_d;
  logic       rd_mode_q, rd_mode_d;
  logic       spi_wr_q, spi_wr_d;
  logic [3:0] spi_wr_addr_q, spi_wr_addr_d;
  logic [7:0] spi_wr_data_q, spi_wr_data_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic [7:0] rx_full;

  assign sclk_s = sync2_q[2];
  assign cs_s   = sync2_q[1];
  assign mosi_s = sync2_q[0];

  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  // cs_prev resets low, so a CS already low when reset releases is never seen
  // as a fall; the rest of that frame is ignored.
  assign cs_fall     = cs_prev_q & ~cs_s;

  // busy only after CS has been seen high once since reset (no stale frame)
  assign busy        = cs_armed_q & ~cs_s;
  assign MISO        = CS ? 1'bz : miso_q;
  assign loc_rdata   = regs_q[loc_addr];
  assign spi_wr      = spi_wr_q;
  assign spi_wr_addr = spi_wr_addr_q;
  assign spi_wr_data = spi_wr_data_q;

  // Next values for synchronizers and edge-detect history
  always_comb begin
    sync1_d     = {SCLK, CS, MOSI};
    sync2_d     = sync1_q;
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    cs_armed_d  = cs_armed_q | cs_s;
  end

  // Synchronizer and edge-detect registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 3'b000;
      sync2_q     <= 3'b000;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      cs_armed_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      cs_armed_q  <= cs_armed_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: CS high always wins and returns to idle
  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD:  if (sample_edge && bit_cnt_q == 3'd7) state_d = ST_DATA;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs and datapath: shifting, command decode, register writes
  always_comb begin
    regs_d = regs_q;
    if (loc_we) regs_d[loc_addr] = loc_wdata;
    bit_cnt_d     = bit_cnt_q;
    addr_d        = addr_q;
    rx_d          = rx_q;
    tx_sh_d       = tx_sh_q;
    miso_d        = miso_q;
    rd_mode_d     = rd_mode_q;
    spi_wr_d      = 1'b0;
    spi_wr_addr_d = spi_wr_addr_q;
    spi_wr_data_d = spi_wr_data_q;
    rx_full       = {rx_q[6:0], mosi_s};
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 3'd0;
        addr_d    = 4'd0;
        rx_d      = 8'h00;
        tx_sh_d   = 8'h00;
        miso_d    = 1'b0;
        rd_mode_d = 1'b0;
      end
      default: begin
        if (!cs_s) begin
          if (sample_edge) begin
            rx_d      = rx_full;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_CMD) begin
                rd_mode_d = rx_full[7];
                if (rx_full[7]) begin
                  tx_sh_d = regs_q[rx_full[3:0]];
                  addr_d  = rx_full[3:0] + 4'd1;
                end else begin
                  addr_d  = rx_full[3:0];
                end
              end else if (rd_mode_q) begin
                tx_sh_d = regs_q[addr_q];
                addr_d  = addr_q + 4'd1;
              end else begin
                // SPI write is applied after the local write so it wins
                regs_d[addr_q] = rx_full;
                spi_wr_d       = 1'b1;
                spi_wr_addr_d  = addr_q;
                spi_wr_data_d  = rx_full;
                addr_d         = addr_q + 4'd1;
              end
            end
          end else if (shift_edge) begin
            miso_d  = tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q     <= 3'd0;
      addr_q        <= 4'd0;
      rx_q          <= 8'h00;
      tx_sh_q       <= 8'h00;
      miso_q        <= 1'b0;
      rd_mode_q     <= 1'b0;
      spi_wr_q      <= 1'b0;
      spi_wr_addr_q <= 4'd0;
      spi_wr_data_q <= 8'h00;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      addr_q        <= addr_d;
      rx_q          <= rx_d;
      tx_sh_q       <= tx_sh_d;
      miso_q        <= miso_d;
      rd_mode_q     <= rd_mode_d;
      spi_wr_q      <= spi_wr_d;
      spi_wr_addr_q <= spi_wr_addr_d;
      spi_wr_data_q <= spi_wr_data_d;
    end
  end

  // Register file, one flop group per entry
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_regs
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) regs_q[gi] <= 8'h00;
        else      regs_q[gi] <= regs_d[gi];
      end
    end
  endgenerate

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: a bit-banged SPI master, a reference
// register model and scoreboard queues for expected writes and read bytes.
module tb_spi_reg_slave;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       SCLK = 1'b0;
  logic       CS = 1'b1;
  logic       MOSI = 1'b0;
  logic       CPOL = 1'b0;
  logic       CPHA = 1'b0;
  logic [3:0] loc_addr = 4'd0;
  logic       loc_we = 1'b0;
  logic [7:0] loc_wdata = 8'h00;
  wire        MISO;
  logic       busy;
  logic [7:0] loc_rdata;
  logic       spi_wr;
  logic [3:0] spi_wr_addr;
  logic [7:0] spi_wr_data;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;
  int wr_exp_total = 0;
  int coll_cyc;
  logic [11:0] wr_exp [$];
  logic [7:0]  rd_exp [$];
  logic [7:0]  model [16];
  logic [12:0] mon_exp;
  logic [7:0]  rb, rb2;
  logic [1:0]  mode;

  spi_reg_slave dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .CPOL(CPOL), .CPHA(CPHA), .busy(busy), .loc_addr(loc_addr),
    .loc_rdata(loc_rdata), .loc_we(loc_we), .loc_wdata(loc_wdata),
    .spi_wr(spi_wr), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every spi_wr pulse is matched against the next expected (addr, data)
  always @(negedge clk) begin
    if (rst === 1'b1 && spi_wr === 1'b1) begin
      wr_seen++;
      mon_exp = (wr_exp.size() > 0) ? {1'b1, wr_exp.pop_front()} : 13'h0;
      $display("spi_wr addr=%h data=%h", spi_wr_addr, spi_wr_data);
      check("spi_wr", {3'b0, 1'b1, spi_wr_addr, spi_wr_data}, {3'b0, mon_exp});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    if (!CPHA) begin
      MOSI = b; tick(HALF);
      SCLK = ~CPOL; r = MISO; tick(HALF);
      SCLK = CPOL;
    end else begin
      SCLK = ~CPOL; MOSI = b; tick(HALF);
      SCLK = CPOL; r = MISO; tick(HALF);
    end
  endtask

  task automatic xfer_byte(input logic [7:0] t, output logic [7:0] r);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(t[i], b);
      r[i] = b;
    end
  endtask

  task automatic cs_begin();
    SCLK = CPOL; tick(8);
    CS = 1'b0; tick(8);
  endtask

  task automatic cs_end();
    tick(8);
    CS = 1'b1; tick(8);
    check("busy_end", {15'b0, busy}, 16'h0000);
    check("wr_count", wr_seen[15:0], wr_exp_total[15:0]);
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
    model[a] = d;
  endtask

  task automatic check_reg(input logic [3:0] a);
    loc_addr = a; #1;
    check($sformatf("reg%0d", a), {8'h00, loc_rdata}, {8'h00, model[a]});
  endtask

  task automatic spi_write(input logic [3:0] a, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] r;
    logic [3:0] a1;
    a1 = a + 4'd1;
    $display("write frame mode=%0d addr=%h data=%h %h", {CPOL, CPHA}, a, d0, d1);
    cs_begin();
    xfer_byte({4'h0, a}, r);
    wr_exp.push_back({a, d0}); wr_exp_total++;
    xfer_byte(d0, r);
    wr_exp.push_back({a1, d1}); wr_exp_total++;
    xfer_byte(d1, r);
    model[a] = d0; model[a1] = d1;
    cs_end();
  endtask

  task automatic spi_read(input logic [3:0] a, input int n);
    logic [7:0] r;
    logic [3:0] idx;
    cs_begin();
    rd_exp.push_back(8'h00);
    xfer_byte({4'h8, a}, r);
    check("rd_cmd_byte", {8'h00, r}, {8'h00, rd_exp.pop_front()});
    for (int k = 0; k < n; k++) begin
      idx = a + 4'(k);
      rd_exp.push_back(model[idx]);
      xfer_byte(8'h00, r);
      $display("read mode=%0d addr=%h got=%h", {CPOL, CPHA}, idx, r);
      check($sformatf("rd_byte%0d", k), {8'h00, r}, {8'h00, rd_exp.pop_front()});
    end
    cs_end();
  endtask

  initial begin
    logic b;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    // Reset state
    tick(5);
    check("rst_busy", {15'b0, busy}, 16'h0000);
    check("rst_spi_wr", {15'b0, spi_wr}, 16'h0000);
    check("rst_wr_addr", {12'h000, spi_wr_addr}, 16'h0000);
    check("rst_wr_data", {8'h00, spi_wr_data}, 16'h0000);
    for (int i = 0; i < 16; i++) check_reg(4'(i));
    rst = 1'b1;
    tick(5);

    // Write/read pair, including address wrap, in every SPI mode
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      CPOL = mode[1]; CPHA = mode[0];
      loc_write(4'd3, 8'h00); loc_write(4'd4, 8'h00);
      loc_write(4'd15, 8'h00); loc_write(4'd0, 8'h00);
      spi_write(4'd3, 8'hA5, 8'h3C);
      check_reg(4'd3); check_reg(4'd4);
      spi_read(4'd3, 2);
      spi_write(4'hF, 8'h11, 8'h22);
      check_reg(4'hF); check_reg(4'd0);
      spi_read(4'hF, 2);
    end
    CPOL = 1'b0; CPHA = 1'b0;

    // Abort mid-byte: nothing written
    loc_write(4'd5, 8'h5A);
    $display("abort frame cmd=05 with 5 data bits");
    cs_begin();
    xfer_byte(8'h05, rb);
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, b);
    cs_end();
    check_reg(4'd5);
    spi_write(4'd5, 8'h66, 8'h67);
    check_reg(4'd5); check_reg(4'd6);

    // Local and SPI write to the same register in the same cycle
    $display("collision frame addr=6 spi=99 local=77");
    cs_begin();
    xfer_byte(8'h06, rb);
    wr_exp.push_back({4'h6, 8'h99}); wr_exp_total++;
    fork
      xfer_byte(8'h99, rb2);
      begin
        loc_addr = 4'd6; loc_wdata = 8'h77; loc_we = 1'b1;
        coll_cyc = 0;
        while (spi_wr !== 1'b1 && coll_cyc < 2000) begin
          @(negedge clk);
          coll_cyc++;
        end
        loc_we = 1'b0;
      end
    join
    model[6] = 8'h99;
    cs_end();
    check("coll_spi_wr_seen", {15'b0, coll_cyc < 2000}, 16'h0001);
    check_reg(4'd6);

    // Reset in the middle of a write frame
    $display("reset mid-frame cmd=07");
    cs_begin();
    xfer_byte(8'h07, rb);
    xfer_bit(1'b0, b); xfer_bit(1'b1, b); xfer_bit(1'b0, b);
    rst = 1'b0;
    tick(3);
    check("rstmid_busy", {15'b0, busy}, 16'h0000);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    wr_exp.delete();
    for (int i = 0; i < 16; i++) check_reg(4'(i));
    rst = 1'b1;
    tick(2);
    xfer_bit(1'b0, b); xfer_bit(1'b0, b); xfer_bit(1'b1, b);
    xfer_bit(1'b0, b); xfer_bit(1'b0, b);
    xfer_byte(8'h45, rb);
    check("rstmid_busy_after", {15'b0, busy}, 16'h0000);
    cs_end();
    check_reg(4'd7);
    spi_write(4'd7, 8'h44, 8'h45);
    check_reg(4'd7); check_reg(4'd8);
    spi_read(4'd7, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
